fpga_serial_transmitter: RTL and testbench
==========================================

# fpga_serial_transmitter

Serializer for the FPGA-to-FPGA link, sitting directly upstream of the receive-side shift register on the partner FPGA: it takes bytes over a valid/ready handshake and drives the single-wire line that becomes that register's serial input. Frames are idle-high and UART-style: start bit, 8 data bits LSB first, optional even parity, one stop bit. A one-byte holding buffer lets the next byte be queued during a frame, so consecutive frames go out with no idle gap.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per line bit; legal range ≥ 2.
- PARITY_EN, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to send; sampled only on an accepting cycle.
- data_valid  input  1  data_in holds a byte to send.
- data_ready  output  1  holding buffer is empty; a byte is accepted on any edge where data_valid & data_ready.
- serial_out  output  1  line output; registered; idles at 1.
- busy  output  1  a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- Reset values: serial_out=1, data_ready=1, busy=0, frame_done=0; FSM=IDLE; holding buffer empty; baud and bit counters 0.
- Holding buffer: one 8-bit register plus a full flag. data_ready is the registered inverse of the full flag.
  - Accept: sets full and captures data_in.
  - Transfer to the shifter: clears full.
  - Accept and transfer never coincide, because data_ready=0 whenever full=1.
  - data_valid while data_ready=0: no effect. The upstream holds data_in, and the byte is neither lost nor duplicated.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_out=1. If the buffer is full, load the shifter, compute parity, clear full, then go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: serial_out=shifter[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to PARITY if PARITY_EN, otherwise STOP.
  - PARITY: serial_out = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. On exit, if the buffer is full, load it and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Cleared on each state entry, counts 0 to CLKS_PER_BIT-1, and wraps on the bit-end cycle.
  - State transitions occur only on that bit-end cycle.
- Bit counter: 3 bits, 0 to 7, with no wrap beyond 7.
- Reset mid-frame: the frame is abandoned, serial_out=1 on the next cycle, and the buffered byte is discarded.
- data_in and data_valid changing mid-frame have no effect on the frame in flight.

## Timing
- Byte accepted from IDLE at edge N: full=1 after N; FSM enters START at N+1; serial_out=0 is visible after edge N+2.
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles.
- data_ready rises on the edge after the buffer transfers to the shifter.
- Back-to-back: the start bit of frame k+1 immediately follows the last stop-bit cycle of frame k.
- frame_done is high for exactly one cycle per frame. It coincides with the final cycle of serial_out=1 in STOP.

## Structure
- Shared package fpga_link_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
  - The matching receiver uses the same package.
- Sub-module baud_tick_counter(clock, reset, clear, tick), parameterised by CLKS_PER_BIT. It is reused by the receiver.

## Test plan
- CLKS_PER_BIT=4, PARITY_EN=0, send 8'hA5 -> serial_out holds each level for 4 cycles, in the order 0, 1,0,1,0,0,1,0,1, 1 (start, data LSB first, stop); 40 cycles total; one frame_done pulse; busy=1 throughout the frame.
- Send 8'h3C with data_valid held high, then 8'hC3 presented at once -> 8'hC3 is accepted during the 8'h3C frame, and data_ready=0 until its transfer. The second start bit begins on the cycle after the first frame's last stop-bit cycle (80 contiguous cycles).
- PARITY_EN=1, send 8'h07 -> parity bit 1 after data bit 7; 44-cycle frame. Send 8'h03 -> parity bit 0.
- Assert reset during DATA bit 3 of 8'hFF with a second byte buffered -> serial_out=1 the cycle after reset; data_ready=1, busy=0; the buffered byte is never transmitted.
- data_valid toggling while data_ready=0 -> exactly one transmission per accepting handshake, with no lost or duplicate bytes, checked by a scoreboard against a line decoder.

Source files
------------

// File: rtl/fpga_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_link_pkg
// Desc     : Shared line-level constants and FSM states for the FPGA-to-FPGA link.
// Revision : 1.0 - initial release
// ============================================================================
package fpga_link_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpga_serial_transmitter_if
// Desc     : Byte valid/ready handshake into the link serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface fpga_serial_transmitter_if;
    import fpga_link_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );

endinterface
`default_nettype wire

// File: rtl/baud_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_counter
// Desc     : Counts 0..CLKS_PER_BIT-1 and flags the bit-end cycle; shared with the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    output logic      tick
);

    localparam int                c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fpga_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : fpga_serial_transmitter
// Desc     : UART-style serializer with a one-byte holding buffer for gapless frames.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_serial_transmitter
    import fpga_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  wire logic                clock,
    input  wire logic                reset,
    fpga_serial_transmitter_if.slave link,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

    link_state_e          r_state;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shifter;
    logic [2:0]           r_bit_idx;
    logic                 r_full;
    logic                 r_data_ready;
    logic                 r_parity;
    logic                 r_serial_out;
    logic                 r_busy;
    logic                 r_frame_done;

    logic w_tick;
    logic w_clear;
    logic w_accept;
    logic w_load;
    logic w_full_next;
    logic w_line;

    // The counter sits at zero while idle, so START always begins a full bit period.
    assign w_clear = (r_state == IDLE);

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_accept    = link.data_valid & r_data_ready;
        w_load      = r_full & ((r_state == IDLE) | ((r_state == STOP) & w_tick));
        w_full_next = r_full;
        if (w_load) begin
            w_full_next = 1'b0;
        end
        if (w_accept) begin
            w_full_next = 1'b1;
        end

        w_line = IDLE_LEVEL;
        case (r_state)
            START:   w_line = START_LEVEL;
            DATA:    w_line = r_shifter[0];
            PARITY:  w_line = r_parity;
            STOP:    w_line = STOP_LEVEL;
            default: w_line = IDLE_LEVEL;
        endcase
    end

    // All outputs are registered from the current state, so they trail the FSM by one
    // cycle together and frame_done lines up with the last stop-bit cycle on the wire.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_shifter    <= '0;
            r_bit_idx    <= '0;
            r_full       <= 1'b0;
            r_data_ready <= 1'b1;
            r_parity     <= 1'b0;
            r_serial_out <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_full       <= w_full_next;
            r_data_ready <= ~w_full_next;
            if (w_accept) begin
                r_hold <= link.data_in;
            end

            r_serial_out <= w_line;
            r_busy       <= (r_state != IDLE);
            r_frame_done <= (r_state == STOP) & w_tick;

            case (r_state)
                IDLE: begin
                    if (r_full) begin
                        r_shifter <= r_hold;
                        r_parity  <= even_parity(r_hold);
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shifter <= r_shifter >> 1;
                        if (r_bit_idx == c_last_bit) begin
                            r_bit_idx <= '0;
                            r_state   <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_full) begin
                            r_shifter <= r_hold;
                            r_parity  <= even_parity(r_hold);
                            r_state   <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign serial_out      = r_serial_out;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign link.data_ready = r_data_ready;

endmodule
`default_nettype wire

// File: tb/tb_fpga_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_serial_transmitter
// Desc     : Self-checking bench: vector table, corner sequences, random scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_serial_transmitter;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpga_serial_transmitter_if bus0 ();
    fpga_serial_transmitter_if bus1 ();

    logic so0, busy0, fd0;
    logic so1, busy1, fd1;

    fpga_serial_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clock(clk), .reset(rst), .link(bus0),
        .serial_out(so0), .busy(busy0), .frame_done(fd0)
    );

    fpga_serial_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clock(clk), .reset(rst), .link(bus1),
        .serial_out(so1), .busy(busy1), .frame_done(fd1)
    );

    // Channel select: 0 = no-parity instance, 1 = parity instance.
    int   cur = 0;
    logic c_so, c_busy, c_fd, c_ready;
    assign c_so    = (cur == 1) ? so1 : so0;
    assign c_busy  = (cur == 1) ? busy1 : busy0;
    assign c_fd    = (cur == 1) ? fd1 : fd0;
    assign c_ready = (cur == 1) ? bus1.data_ready : bus0.data_ready;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (cur == 1) begin
            bus1.data_valid = v;
            bus1.data_in    = d;
        end else begin
            bus0.data_valid = v;
            bus0.data_in    = d;
        end
    endtask

    // Reference frame: line level of bit slot k (start, 8 data LSB first, [parity], stop).
    function automatic logic model_bit(input logic [7:0] d, input bit pe, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((c_busy !== 1'b0 || c_ready !== 1'b1 || c_so !== 1'b1) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check({name, "_idle_timeout"}, guard, 0);
    endtask

    // Line decoder on the no-parity instance: mid-bit sampling, one byte per frame.
    logic [7:0] dec_q[$];
    logic [7:0] dec_byte   = 8'h00;
    logic       dec_active = 1'b0;
    logic       dec_prev   = 1'b1;
    int         dec_cnt    = 0;
    int         stop_err   = 0;

    always @(negedge clk) begin
        if (rst) begin
            dec_active <= 1'b0;
            dec_prev   <= 1'b1;
            dec_cnt    <= 0;
        end else begin
            dec_prev <= so0;
            if (!dec_active) begin
                if (dec_prev && !so0) begin
                    dec_active <= 1'b1;
                    dec_cnt    <= 1;
                end
            end else begin
                if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % CPB) == 0)
                    dec_byte[3'((dec_cnt - 6) / CPB)] <= so0;
                if (dec_cnt == 38) begin
                    dec_q.push_back(dec_byte);
                    if (!so0) stop_err <= stop_err + 1;
                end
                if (dec_cnt == 39) dec_active <= 1'b0;
                else dec_cnt <= dec_cnt + 1;
            end
        end
    end

    typedef struct {
        bit         pe;
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vector(input vec_t v, input int idx);
        int   len, bad_wave, bad_busy, n_done;
        logic done_last, par_seen;
        cur       = v.pe ? 1 : 0;
        len       = (10 + (v.pe ? 1 : 0)) * CPB;
        bad_wave  = 0;
        bad_busy  = 0;
        n_done    = 0;
        done_last = 1'b0;
        par_seen  = 1'bx;
        wait_idle($sformatf("v%0d", idx));
        @(posedge clk); #1 drive(1'b1, v.data);
        @(posedge clk); #1 drive(1'b0, 8'h00);
        // Accepted on edge N; first start-bit sample follows edge N+2.
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (c_so !== model_bit(v.data, v.pe, i / CPB)) bad_wave++;
            if (c_busy !== 1'b1) bad_busy++;
            if (c_fd === 1'b1) n_done++;
            if (i == len - 1) done_last = c_fd;
            if (i == 9 * CPB + CPB / 2) par_seen = c_so;
        end
        @(negedge clk);
        check($sformatf("v%0d_wave", idx), bad_wave, 0);
        check($sformatf("v%0d_busy", idx), bad_busy, 0);
        check($sformatf("v%0d_done_count", idx), n_done, 1);
        check($sformatf("v%0d_done_last", idx), done_last, 1);
        check($sformatf("v%0d_idle_after", idx), {c_so, c_busy}, 2'b10);
        if (v.pe) check($sformatf("v%0d_parity", idx), par_seen, v.exp_par);
    endtask

    task automatic seq_back_to_back();
        logic so_r[100], rdy_r[100], fd_r[100], busy_r[100];
        int   s, guard, bad_wave, bad_busy, bad_rdy, n_done;
        logic exp;
        cur = 0;
        wait_idle("b2b");
        @(posedge clk); #1 drive(1'b1, 8'h3C);
        @(posedge clk); #1 drive(1'b1, 8'hC3);
        guard = 0;
        @(negedge clk);
        while (c_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("b2b_second_accept_timeout", guard, 0);
        @(posedge clk); #1 drive(1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            so_r[i]   = c_so;
            rdy_r[i]  = c_ready;
            fd_r[i]   = c_fd;
            busy_r[i] = c_busy;
        end
        s = 0;
        while (s < 10 && so_r[s] !== 1'b0) s++;
        check("b2b_start_found", (s < 10), 1);
        if (s < 10) begin
            bad_wave = 0;
            bad_busy = 0;
            bad_rdy  = 0;
            n_done   = 0;
            for (int k = 0; k < 80; k++) begin
                exp = (k < 40) ? model_bit(8'h3C, 1'b0, k / CPB) : model_bit(8'hC3, 1'b0, (k - 40) / CPB);
                if (so_r[s+k] !== exp) bad_wave++;
                if (busy_r[s+k] !== 1'b1) bad_busy++;
                if (fd_r[s+k] === 1'b1) n_done++;
            end
            for (int k = 0; k <= s + 37; k++) if (rdy_r[k] !== 1'b0) bad_rdy++;
            check("b2b_wave_80", bad_wave, 0);
            check("b2b_busy", bad_busy, 0);
            check("b2b_ready_low_while_held", bad_rdy, 0);
            check("b2b_ready_after_xfer", rdy_r[s+45], 1);
            check("b2b_done_count", n_done, 2);
            check("b2b_done_pos", {fd_r[s+39], fd_r[s+79]}, 2'b11);
            check("b2b_idle_after", {so_r[s+80], busy_r[s+80]}, 2'b10);
        end
    endtask

    task automatic seq_reset_mid();
        int guard, bad;
        cur = 0;
        wait_idle("rst");
        @(posedge clk); #1 drive(1'b1, 8'hFF);
        @(posedge clk); #1 drive(1'b0, 8'h00);
        guard = 0;
        @(negedge clk);
        while (c_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1 drive(1'b1, 8'h55);
        @(posedge clk); #1 drive(1'b0, 8'h00);
        guard = 0;
        @(negedge clk);
        while (c_so !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_start_seen", c_so, 0);
        repeat (17) @(negedge clk);
        check("rst_pre_line_bit3", c_so, 1);
        check("rst_pre_buffered", c_ready, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_post_state", {c_so, c_ready, c_busy, c_fd}, 4'b1100);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (c_so !== 1'b1 || c_busy !== 1'b0 || c_ready !== 1'b1) bad++;
        end
        check("rst_buffer_discarded", bad, 0);
    endtask

    task automatic seq_random();
        logic [7:0] sent_q[$];
        logic [7:0] d;
        int         guard;
        bit         acc;
        cur = 0;
        wait_idle("rnd");
        dec_q.delete();
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom_range(0, 255));
            sent_q.push_back(d);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 2000) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 1) == 1) drive(1'b1, d);
                else drive(1'b0, 8'($urandom_range(0, 255)));
                @(negedge clk);
                if (bus0.data_valid === 1'b1 && bus0.data_ready === 1'b1) acc = 1'b1;
                guard++;
            end
            if (!acc) check($sformatf("rnd_accept_timeout_%0d", k), guard, 0);
        end
        @(posedge clk); #1 drive(1'b0, 8'h00);
        wait_idle("rnd_end");
        repeat (8) @(negedge clk);
        check("rnd_count", dec_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size(); i++)
            if (i < dec_q.size()) check($sformatf("rnd_byte_%0d", i), dec_q[i], sent_q[i]);
        check("rnd_stop_errors", stop_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 8'h07, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 1'b0};
        vecs[3] = '{1'b0, 8'h5A, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 1'b1};
        vecs[5] = '{1'b1, 8'hFF, 1'b0};

        bus0.data_valid = 1'b0;
        bus0.data_in    = 8'h00;
        bus1.data_valid = 1'b0;
        bus1.data_in    = 8'h00;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", {so0, bus0.data_ready, busy0, fd0}, 4'b1100);
        check("reset_dut1", {so1, bus1.data_ready, busy1, fd1}, 4'b1100);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle_dut0", {so0, bus0.data_ready, busy0, fd0}, 4'b1100);
        check("post_reset_idle_dut1", {so1, bus1.data_ready, busy1, fd1}, 4'b1100);

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        seq_back_to_back();
        seq_reset_mid();
        seq_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
